// File: rtl/arb_pkg.sv
// Shared encodings for the SRAM request arbiter: owner tags, size codes, grant states.
package arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } grant_state_e;

endpackage

// File: rtl/owner_fifo.sv
// One-bit owner-tag FIFO recording which requester issued each outstanding transaction.
module owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_own,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = slot_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      slot_d[wr_ptr_q] = push_own;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-handshake arbiter: data-first with bounded fetch starvation,
// grant locked until address accept, in-order response routing by owner tag.
module sram_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_err
);

  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  grant_state_e     state_q, state_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             resp_err_q, resp_err_d;
  logic             sel_data, req_int, accept, starved, resp_hit;
  logic             fifo_head, fifo_full, fifo_empty;

  assign starved = (starve_q == STV_W'(STARVE_LIMIT));

  // Grant selection and lock tracking; reset masks the downstream request.
  always_comb begin
    state_d  = state_q;
    sel_data = 1'b0;
    req_int  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full) begin
          if (data_req && !starved) begin
            sel_data = 1'b1;
            req_int  = 1'b1;
          end else if (inst_req) begin
            req_int = 1'b1;
          end
        end
        if (req_int && !mem_addr_ok) begin
          state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
        end
      end
      ST_LOCK_I: begin
        req_int = 1'b1;
        if (mem_addr_ok) state_d = ST_IDLE;
      end
      ST_LOCK_D: begin
        sel_data = 1'b1;
        req_int  = 1'b1;
        if (mem_addr_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!resetn) req_int = 1'b0;
  end

  assign accept       = req_int & mem_addr_ok;
  assign mem_req      = req_int;
  assign mem_wr       = sel_data ? data_wr    : inst_wr;
  assign mem_size     = sel_data ? data_size  : inst_size;
  assign mem_addr     = sel_data ? data_addr  : inst_addr;
  assign mem_wstrb    = sel_data ? data_wstrb : inst_wstrb;
  assign mem_wdata    = sel_data ? data_wdata : inst_wdata;
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept & sel_data;

  // Responses return in issue order, so the FIFO head names the owner.
  assign resp_hit     = mem_data_ok & ~fifo_empty & resetn;
  assign inst_data_ok = resp_hit & (fifo_head == OWN_INST);
  assign data_data_ok = resp_hit & (fifo_head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_own (sel_data ? OWN_DATA : OWN_INST),
    .pop      (mem_data_ok),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || (accept && !sel_data)) begin
      starve_d = '0;
    end else if (accept && sel_data && !starved) begin
      starve_d = starve_q + STV_W'(1);
    end
    resp_err_d = resp_err_q | (mem_data_ok & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the pipeline's instruction-fetch requester and its load/store requester. It sits between the CPU core's fetch and memory stages and the single downstream memory port, ahead of a future AXI bridge. It locks a grant until the address is accepted and tracks the owner of each outstanding transaction so in-order responses reach the correct requester. It prioritises data with a bounded anti-starvation rule for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- OUTSTANDING, 2, max accepted-but-unanswered transactions (owner FIFO depth, power of two, ≥1)
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- inst_req / data_req  in  1  request valid; held stable with all attributes until matching addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  ADDR_W  byte address
- inst_wstrb / data_wstrb  in  DATA_W/8  byte enables
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle
- inst_rdata / data_rdata  out  DATA_W  read data, mirrors mem_rdata
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  as above  downstream request
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response, in issue order
- mem_rdata  in  DATA_W  downstream read data
- resp_err  out  1  sticky: mem_data_ok seen with owner FIFO empty

## Operation
- Grant state: IDLE (no locked grant), LOCK_I, LOCK_D.
- IDLE: if owner FIFO full → mem_req = 0. Else select: data if data_req and not starved; inst if inst_req and (no data_req or starved). Drive mem_* from the selected requester. On mem_addr_ok the transaction is accepted in the same cycle and the FSM stays IDLE. Without mem_addr_ok, go to LOCK_x for the selected requester.
- LOCK_x: mem_* driven from x regardless of the other requester. On mem_addr_ok → IDLE. The lock holds even if the other requester has higher priority.
- addr_ok to the owner = mem_req & mem_addr_ok & (owner selected). The non-selected requester always sees addr_ok = 0.
- Owner FIFO: push the owner bit on accept; pop on mem_data_ok. Head owner routes data_ok: inst_data_ok = mem_data_ok & head==INST, likewise data. rdata goes to both ports unconditionally.
- Simultaneous push and pop: both happen and the count is unchanged. When full, no push is possible because mem_req is gated. A pop frees a slot in the next cycle, not combinationally.
- mem_data_ok with FIFO empty: ignored, no data_ok, resp_err ← 1 until reset.
- Starve counter (width ≥ clog2(STARVE_LIMIT+1)):
  - increments on each data accept while inst_req = 1;
  - clears on inst accept, or on any cycle with inst_req = 0;
  - starved = counter == STARVE_LIMIT.

## Timing
- Request path fully combinational: req → mem_req and mem_addr_ok → x_addr_ok have zero added latency.
- Response path combinational: mem_data_ok → x_data_ok in the same cycle.
- Throughput: one accept per cycle while the FIFO is not full.
- Reset values (resetn sampled low):
  - state IDLE, FIFO empty, starve counter 0, resp_err 0;
  - while resetn = 0, mem_req, both addr_ok and both data_ok are forced 0.
- Reset mid-transaction discards all outstanding owner tags. Downstream is reset in the same cycle by the integrator.

## Structure
- Shared package `arb_pkg`: owner encoding OWN_INST = 1'b0, OWN_DATA = 1'b1; size codes SZ_B/SZ_H/SZ_W; grant state enum.
- One sub-module `owner_fifo`: depth OUTSTANDING, width 1, with push, pop, head, full and empty outputs and synchronous active-low reset.
- Arbiter FSM, starve counter and muxes live in the top.

## Test plan
- Data read only: data_req=1, addr=0x1000, mem_addr_ok=1 the same cycle, mem_data_ok next cycle with rdata=0xDEADBEEF → data_addr_ok pulses once; data_data_ok with 0xDEADBEEF; inst_* stay 0.
- Lock: inst_req alone, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 2 → mem_addr stays the inst address until accept; the next cycle grants data.
- Full FIFO (OUTSTANDING=2): two accepted reads, no data_ok, third request pending → mem_req=0. A data_ok arrives → third request accepted the following cycle.
- Ordering: accept inst@0x0, then data@0x2000, two data_ok with rdata 0x11, 0x22 → inst_data_ok with 0x11, then data_data_ok with 0x22.
- Starvation: both requesting continuously, mem_addr_ok=1 → grant sequence D,D,D,D,I repeating.
- Error and reset: mem_data_ok with empty FIFO → resp_err=1, no data_ok. resetn=0 for one cycle mid-lock → resp_err=0, FIFO empty, mem_req=0 during reset.
